// File: rtl/vending_machine_multi.sv
// ============================================================================
// Module   : vending_machine_multi
// Purpose  : Multi-product vending controller. Accepts two coin denominations
//            into a capped credit register, vends one of NUM_ITEMS products at
//            price(i) = PRICE_BASE + i*PRICE_STEP, then returns the remaining
//            credit as one change pulse per COIN_A_VAL. All outputs registered.
// Ports    : clk           - system clock, rising edge
//            rst_n         - asynchronous active-low reset
//            i_coin[1:0]   - 00 none, 01 coin A, 10 coin B, 11 invalid
//            i_sel         - product select for a buy
//            i_buy         - purchase request
//            i_cancel      - refund request
//            o_dispense    - one-cycle vend pulse
//            o_item        - vended product, 0 unless o_dispense
//            o_change      - one pulse per COIN_A_VAL returned
//            o_coin_reject - one-cycle pulse, coin not credited
//            o_buy_err     - one-cycle pulse, buy refused
//            o_credit      - current credit
//            o_busy        - high while vending or refunding
//            o_sold_out    - per-product empty flags
// Options  : `define STOCK_COUNT_EN enables per-product stock counters that
//            start at STOCK_INIT; otherwise stock is unlimited and
//            o_sold_out is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_machine_multi #(
  parameter int NUM_ITEMS  = 4,
  parameter int SEL_W      = 2,
  parameter int CREDIT_W   = 6,
  parameter int COIN_A_VAL = 5,
  parameter int COIN_B_VAL = 10,
  parameter int PRICE_BASE = 15,
  parameter int PRICE_STEP = 5,
  parameter int MAX_CREDIT = 40,
  parameter int STOCK_INIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           i_coin,
  input  logic [SEL_W-1:0]     i_sel,
  input  logic                 i_buy,
  input  logic                 i_cancel,
  output logic                 o_dispense,
  output logic [SEL_W-1:0]     o_item,
  output logic                 o_change,
  output logic                 o_coin_reject,
  output logic                 o_buy_err,
  output logic [CREDIT_W-1:0]  o_credit,
  output logic                 o_busy,
  output logic [NUM_ITEMS-1:0] o_sold_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_REFUND  = 2'd3;

  localparam logic [CREDIT_W-1:0] c_unit = CREDIT_W'(COIN_A_VAL);

  logic [1:0]          r_state;
  logic [CREDIT_W-1:0] r_credit;

  logic [1:0]          w_state_nxt;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                w_dispense;
  logic [SEL_W-1:0]    w_item;
  logic                w_change;
  logic                w_coin_rej;
  logic                w_buy_err;

  logic [CREDIT_W-1:0] w_coin_val;
  logic                w_coin_valid;
  logic [CREDIT_W:0]   w_sum;
  logic [31:0]         w_price;
  logic                w_sel_ok;
  logic                w_afford;
  logic                w_in_stock;

  always_comb begin
    w_coin_valid = (i_coin == 2'b01) || (i_coin == 2'b10);
    w_coin_val   = (i_coin == 2'b10) ? CREDIT_W'(COIN_B_VAL) : c_unit;
  end

  // One extra bit so the ceiling check cannot be fooled by wrap-around.
  assign w_sum    = {1'b0, r_credit} + {1'b0, w_coin_val};
  // Price evaluated at 32 bits so an out-of-range product never aliases.
  assign w_price  = 32'(PRICE_BASE) + 32'(i_sel) * 32'(PRICE_STEP);
  assign w_sel_ok = 32'(i_sel) < 32'(NUM_ITEMS);
  assign w_afford = 32'(r_credit) >= w_price;

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_dispense   = 1'b0;
    w_item       = '0;
    w_change     = 1'b0;
    w_coin_rej   = 1'b0;
    w_buy_err    = 1'b0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        // Cancel is only meaningful with credit held; in IDLE it falls through.
        if (i_cancel && (r_state == S_COLLECT)) begin
          w_state_nxt = S_REFUND;
          w_coin_rej  = (i_coin != 2'b00);
        end else if (i_buy) begin
          // A coin alongside a buy is never credited, even if the buy fails.
          w_coin_rej = (i_coin != 2'b00);
          if ((r_state == S_COLLECT) && w_sel_ok && w_afford && w_in_stock) begin
            w_state_nxt  = S_VEND;
            w_dispense   = 1'b1;
            w_item       = i_sel;
            w_credit_nxt = r_credit - w_price[CREDIT_W-1:0];
          end else begin
            w_buy_err = 1'b1;
          end
        end else if (w_coin_valid) begin
          if (w_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            w_credit_nxt = w_sum[CREDIT_W-1:0];
            w_state_nxt  = S_COLLECT;
          end else begin
            w_coin_rej = 1'b1;
          end
        end else if (i_coin == 2'b11) begin
          w_coin_rej = 1'b1;
        end
      end
      S_VEND: begin
        w_coin_rej  = (i_coin != 2'b00);
        w_state_nxt = (r_credit != '0) ? S_REFUND : S_IDLE;
      end
      default: begin  // S_REFUND
        w_coin_rej = (i_coin != 2'b00);
        if (r_credit > c_unit) begin
          w_change     = 1'b1;
          w_credit_nxt = r_credit - c_unit;
        end else begin
          // Last unit (or nothing left): finish and never underflow.
          w_change     = (r_credit != '0);
          w_credit_nxt = '0;
          w_state_nxt  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_credit      <= '0;
      o_dispense    <= 1'b0;
      o_item        <= '0;
      o_change      <= 1'b0;
      o_coin_reject <= 1'b0;
      o_buy_err     <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      o_dispense    <= w_dispense;
      o_item        <= w_item;
      o_change      <= w_change;
      o_coin_reject <= w_coin_rej;
      o_buy_err     <= w_buy_err;
      o_busy        <= (w_state_nxt == S_VEND) || (w_state_nxt == S_REFUND);
    end
  end

  assign o_credit = r_credit;

`ifdef STOCK_COUNT_EN
  localparam int STOCK_W = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);

  logic [NUM_ITEMS-1:0] w_has_stock;

  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_stock
    logic [STOCK_W-1:0] r_cnt;
    logic               r_empty;
    logic               w_dec;
    logic [STOCK_W-1:0] w_cnt_nxt;

    assign w_dec     = w_dispense && (32'(i_sel) == 32'(gi));
    assign w_cnt_nxt = w_dec ? (r_cnt - 1'b1) : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= STOCK_W'(STOCK_INIT);
        r_empty <= (STOCK_INIT == 0);
      end else begin
        r_cnt   <= w_cnt_nxt;
        r_empty <= (w_cnt_nxt == '0);
      end
    end

    assign w_has_stock[gi] = (r_cnt != '0);
    assign o_sold_out[gi]  = r_empty;
  end

  always_comb begin
    w_in_stock = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (32'(i_sel) == 32'(i)) w_in_stock = w_has_stock[i];
    end
  end
`else
  assign w_in_stock = 1'b1;
  assign o_sold_out = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vending_machine_multi.sv
// ============================================================================
// Module   : tb_vending_machine_multi
// Purpose  : Directed self-checking bench for vending_machine_multi with
//            default prices 15/20/25/30, coin A = 5, coin B = 10, cap 40.
//            Stock limit checks apply when STOCK_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vending_machine_multi;

  logic       clk;
  logic       rst_n;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       buy;
  logic       cancel;
  logic       dispense;
  logic [1:0] item;
  logic       change;
  logic       coin_reject;
  logic       buy_err;
  logic [5:0] credit;
  logic       busy;
  logic [3:0] sold_out;

  int n_cmp;
  int n_err;

  vending_machine_multi #(
    .STOCK_INIT(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_coin       (coin),
    .i_sel        (sel),
    .i_buy        (buy),
    .i_cancel     (cancel),
    .o_dispense   (dispense),
    .o_item       (item),
    .o_change     (change),
    .o_coin_reject(coin_reject),
    .o_buy_err    (buy_err),
    .o_credit     (credit),
    .o_busy       (busy),
    .o_sold_out   (sold_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic tick(input logic [1:0] c, input logic b, input logic [1:0] s,
                      input logic x);
    coin = c; buy = b; sel = s; cancel = x;
    @(posedge clk);
    #1;
    coin = 2'b00; buy = 1'b0; cancel = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; coin = 2'b00; sel = 2'd0; buy = 1'b0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_sold_out", sold_out, 0);

    // IDLE buy is refused
    tick(2'b00, 1'b1, 2'd0, 1'b0);
    chk("idle_buy_err", buy_err, 1);
    chk("idle_buy_credit", credit, 0);

    // 1: B then A, buy item 0 exact
    tick(2'b10, 1'b0, 2'd0, 1'b0);
    chk("t1_credit10", credit, 10);
    chk("t1_buy_err_clear", buy_err, 0);
    tick(2'b01, 1'b0, 2'd0, 1'b0);
    chk("t1_credit15", credit, 15);
    tick(2'b00, 1'b1, 2'd0, 1'b0);
    chk("t1_dispense", dispense, 1);
    chk("t1_item", item, 0);
    chk("t1_credit0", credit, 0);
    chk("t1_busy_vend", busy, 1);
    tick(2'b00, 1'b0, 2'd0, 1'b0);
    chk("t1_dispense_off", dispense, 0);
    chk("t1_no_change", change, 0);
    chk("t1_idle_busy", busy, 0);

    // 2: B,B buy item 0, one change pulse
    tick(2'b10, 1'b0, 2'd0, 1'b0);
    tick(2'b10, 1'b0, 2'd0, 1'b0);
    chk("t2_credit20", credit, 20);
    tick(2'b00, 1'b1, 2'd0, 1'b0);
    chk("t2_dispense", dispense, 1);
    chk("t2_credit5", credit, 5);
    chk("t2_busy1", busy, 1);
    tick(2'b00, 1'b0, 2'd0, 1'b0);
    chk("t2_busy2", busy, 1);
    chk("t2_change_pre", change, 0);
    chk("t2_dispense_off", dispense, 0);
    tick(2'b00, 1'b0, 2'd0, 1'b0);
    chk("t2_change", change, 1);
    chk("t2_credit0", credit, 0);
    chk("t2_busy_off", busy, 0);
    tick(2'b00, 1'b0, 2'd0, 1'b0);
    chk("t2_change_off", change, 0);

    // 3: fill to 40, reject over-cap coin, cancel -> 8 pulses
    repeat (4) tick(2'b10, 1'b0, 2'd0, 1'b0);
    chk("t3_credit40", credit, 40);
    tick(2'b01, 1'b0, 2'd0, 1'b0);
    chk("t3_reject", coin_reject, 1);
    chk("t3_credit_hold", credit, 40);
    tick(2'b00, 1'b0, 2'd0, 1'b1);
    chk("t3_reject_off", coin_reject, 0);
    chk("t3_cancel_busy", busy, 1);
    chk("t3_cancel_credit", credit, 40);
    for (int k = 1; k <= 8; k++) begin
      tick(2'b00, 1'b0, 2'd0, 1'b0);
      chk($sformatf("t3_change_%0d", k), change, 1);
      chk($sformatf("t3_credit_%0d", k), credit, 40 - 5 * k);
      if (k < 8) chk($sformatf("t3_busy_%0d", k), busy, 1);
    end
    chk("t3_end_busy", busy, 0);
    tick(2'b00, 1'b0, 2'd0, 1'b0);
    chk("t3_change_off", change, 0);

    // 4: unaffordable buy, coin alongside buy, invalid coin
    tick(2'b10, 1'b0, 2'd0, 1'b0);
    tick(2'b00, 1'b1, 2'd2, 1'b0);
    chk("t4_buy_err", buy_err, 1);
    chk("t4_credit10", credit, 10);
    chk("t4_no_dispense", dispense, 0);
    tick(2'b00, 1'b0, 2'd2, 1'b0);
    chk("t4_buy_err_off", buy_err, 0);
    tick(2'b01, 1'b1, 2'd2, 1'b0);
    chk("t4_coin_buy_reject", coin_reject, 1);
    chk("t4_coin_buy_err", buy_err, 1);
    chk("t4_coin_buy_credit", credit, 10);
    tick(2'b11, 1'b0, 2'd0, 1'b0);
    chk("t4_invalid_reject", coin_reject, 1);
    chk("t4_invalid_credit", credit, 10);
    tick(2'b00, 1'b0, 2'd0, 1'b1);
    tick(2'b01, 1'b0, 2'd0, 1'b0);
    chk("t4_refund_reject", coin_reject, 1);
    chk("t4_refund_credit", credit, 5);
    tick(2'b00, 1'b0, 2'd0, 1'b0);
    chk("t4_flush_credit", credit, 0);

    // 5: async reset mid-refund
    tick(2'b10, 1'b0, 2'd0, 1'b0);
    tick(2'b10, 1'b0, 2'd0, 1'b0);
    tick(2'b01, 1'b0, 2'd0, 1'b0);
    chk("t5_credit25", credit, 25);
    tick(2'b00, 1'b0, 2'd0, 1'b1);
    tick(2'b00, 1'b0, 2'd0, 1'b0);
    chk("t5_mid_change", change, 1);
    chk("t5_mid_credit", credit, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_credit", credit, 0);
    chk("t5_rst_change", change, 0);
    chk("t5_rst_busy", busy, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_post_credit", credit, 0);
    chk("t5_post_change", change, 0);
    tick(2'b01, 1'b0, 2'd0, 1'b0);
    chk("t5_idle_coin", credit, 5);
    tick(2'b00, 1'b0, 2'd0, 1'b1);
    tick(2'b00, 1'b0, 2'd0, 1'b0);
    chk("t5_flush_credit", credit, 0);

    // 6: item 3 at 30; stock of 1 when counting is enabled
    tick(2'b10, 1'b0, 2'd0, 1'b0);
    tick(2'b10, 1'b0, 2'd0, 1'b0);
    tick(2'b01, 1'b0, 2'd0, 1'b0);
    tick(2'b00, 1'b1, 2'd3, 1'b0);
    chk("t6_25_buy_err", buy_err, 1);
    tick(2'b01, 1'b0, 2'd0, 1'b0);
    chk("t6_credit30", credit, 30);
    tick(2'b00, 1'b1, 2'd3, 1'b0);
    chk("t6_dispense", dispense, 1);
    chk("t6_item", item, 3);
    chk("t6_credit0", credit, 0);
`ifdef STOCK_COUNT_EN
    chk("t6_sold_out", sold_out, 4'b1000);
`else
    chk("t6_sold_out", sold_out, 4'b0000);
`endif
    tick(2'b00, 1'b0, 2'd0, 1'b0);
    chk("t6_item_clear", item, 0);
    repeat (3) tick(2'b10, 1'b0, 2'd0, 1'b0);
    chk("t6_credit30b", credit, 30);
    tick(2'b00, 1'b1, 2'd3, 1'b0);
`ifdef STOCK_COUNT_EN
    chk("t6_rebuy_err", buy_err, 1);
    chk("t6_rebuy_credit", credit, 30);
    tick(2'b00, 1'b0, 2'd0, 1'b1);
    repeat (6) tick(2'b00, 1'b0, 2'd0, 1'b0);
`else
    chk("t6_rebuy_dispense", dispense, 1);
    chk("t6_rebuy_credit", credit, 0);
    tick(2'b00, 1'b0, 2'd0, 1'b0);
`endif
    chk("t6_final_credit", credit, 0);
    chk("t6_final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
